// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the MEM stage. Accepts a held MemRead/MemWrite
//   request, completes it after LATENCY cycles with a one-cycle ready pulse and
//   stalls the pipeline while the request is outstanding.
//
// Ports
//   clock, reset          rising-edge clock, async active-low reset
//   MemRead, MemWrite     request strobes, held by the requester until ready
//   address, WriteData    byte address and store data (latched on acceptance)
//   Read_data             load data, valid only while ready=1
//   ready                 one-cycle completion pulse
//   stall                 combinational (MemRead|MemWrite) & ~ready
//   err                   misaligned-access flag, valid only while ready=1
//   access_count          completed transactions, wraps at 16 bits
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] WriteData,
    output logic [31:0] Read_data,
    output logic        ready,
    output logic        stall,
    output logic        err,
    output logic [15:0] access_count
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [31:0] mem [DEPTH];

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic                   mis_q, mis_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [15:0]            count_q, count_d;

    logic                   req;
    logic                   do_access;
    logic [ADDR_BITS-1:0]   acc_idx;
    logic                   acc_mis;
    logic                   acc_rd;
    logic                   acc_wr;
    logic [31:0]            acc_wdata;
    logic                   mem_we;

    // Upper address bits do not take part in the word index; addresses alias.
    logic unused_addr;
    assign unused_addr = ^address[31:ADDR_BITS+2];

    assign req = MemRead | MemWrite;

    // With LATENCY=1 the access happens at the accepting edge, so it must use
    // the live inputs; otherwise it uses the latched transaction.
    always_comb begin
        if (state_q == IDLE) begin
            acc_idx   = address[ADDR_BITS+1:2];
            acc_mis   = address[1:0] != 2'b00;
            acc_rd    = MemRead;
            acc_wr    = MemWrite;
            acc_wdata = WriteData;
        end else begin
            acc_idx   = idx_q;
            acc_mis   = mis_q;
            acc_rd    = rd_q;
            acc_wr    = wr_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        mis_d     = mis_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        count_d   = count_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        rdata_d   = 32'h0;
        do_access = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = address[ADDR_BITS+1:2];
                    mis_d   = address[1:0] != 2'b00;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    wdata_d = WriteData;
                    cnt_d   = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d   = DONE;
                        do_access = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = DONE;
                    do_access = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = count_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs for the DONE cycle are registered at the edge entering it.
        // Read data is sampled before the write lands (read-before-write).
        if (do_access) begin
            ready_d = 1'b1;
            err_d   = acc_mis;
            rdata_d = (acc_rd && !acc_mis) ? mem[acc_idx] : 32'h0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            count_q <= count_d;
        end
    end

    // Array is never cleared; a held reset blocks the commit edge.
    assign mem_we = do_access & acc_wr & ~acc_mis & reset;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign Read_data    = rdata_q;
    assign ready        = ready_q;
    assign err          = err_q;
    assign access_count = count_q;
    assign stall        = req & ~ready_q;

endmodule
